// File: rtl/mem_req_arbiter_pkg.sv
// Shared constants for the memory request arbiter: access direction flags,
// default widths, arbiter state encoding and transaction owner encoding.
package mem_req_arbiter_pkg;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 32;

    localparam logic READ_FLAG  = 1'b0;
    localparam logic WRITE_FLAG = 1'b1;

    // Instruction fetches are always full-word reads.
    localparam logic [2:0] FETCH_LEN = 3'd4;

    typedef enum logic {
        ArbIdle,
        ArbWait
    } arb_state_e;

    typedef enum logic {
        OwnIf,
        OwnLs
    } owner_e;

endpackage

// File: rtl/mem_req_arbiter_req_slot.sv
// One-deep pulse-capture buffer.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   en_i           global enable; state holds when low
//   req_i          request pulse, payload_i valid with it
//   drop_i         ignore the request pulse at this edge
//   clr_i          empty the slot at this edge
//   take_i         slot is being granted at this edge (may refill at the same edge)
//   valid_o        slot holds a request
//   payload_o      latched payload
//   ovf_o          pulse arrived while the slot was full and not being freed
module mem_req_arbiter_req_slot #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         req_i,
    input  logic         drop_i,
    input  logic         clr_i,
    input  logic         take_i,
    input  logic [W-1:0] payload_i,
    output logic         valid_o,
    output logic [W-1:0] payload_o,
    output logic         ovf_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] payload_q;
    logic         free;
    logic         accept;

    always_comb begin
        free    = !valid_q || take_i || clr_i;
        accept  = req_i && !drop_i && free;
        ovf_o   = req_i && !drop_i && !free;
        valid_d = valid_q;
        if (accept) begin
            valid_d = 1'b1;
        end else if (take_i || clr_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else if (en_i) begin
            valid_q <= valid_d;
            if (accept) begin
                payload_q <= payload_i;
            end
        end
    end

    assign valid_o   = valid_q;
    assign payload_o = payload_q;

endmodule

// File: rtl/mem_req_arbiter.sv
// Front-end arbiter for the byte-serial memory controller. Captures IF and LSU
// request pulses into one-deep slots, issues one transaction at a time with LSU
// priority (IF is granted after at most LS_BURST_MAX consecutive LSU grants),
// routes completions to their owner and squashes flushed reads.
// Ports:
//   clk, rst, rdy            clock, async active-high reset, global enable
//   stop_signal              pipeline flush (level)
//   if_req/if_pc             fetch request; if_done/if_inst fetch completion
//   ls_req/rw/len/addr/wdata LSU request; ls_done/ls_rdata LSU completion
//   mc_*                     controller start/payload and done/rdata
//   busy                     transaction in flight
//   proto_err                sticky: request pulse into an occupied slot
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_WIDTH,
    parameter int unsigned DATA_W       = DATA_WIDTH,
    parameter int unsigned LS_BURST_MAX = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              stop_signal,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              if_done,
    output logic [DATA_W-1:0] if_inst,
    input  logic              ls_req,
    input  logic              ls_rw,
    input  logic [2:0]        ls_len,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_done,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mc_start,
    output logic              mc_rw,
    output logic [2:0]        mc_len,
    output logic [ADDR_W-1:0] mc_addr,
    output logic [DATA_W-1:0] mc_wdata,
    input  logic              mc_done,
    input  logic [DATA_W-1:0] mc_rdata,
    output logic              busy,
    output logic              proto_err
);

    localparam int unsigned LW = 1 + 3 + ADDR_W + DATA_W;
    localparam logic [CNT_W-1:0] BurstMax = CNT_W'(LS_BURST_MAX);

    arb_state_e        state_q;
    owner_e            owner_q;
    logic              squash_q;
    logic [CNT_W-1:0]  burst_cnt_q;
    logic              if_done_q, ls_done_q, mc_start_q, mc_rw_q, busy_q, proto_err_q;
    logic [DATA_W-1:0] if_inst_q, ls_rdata_q, mc_wdata_q;
    logic [2:0]        mc_len_q;
    logic [ADDR_W-1:0] mc_addr_q;

    logic              if_valid, ls_valid, if_ovf, ls_ovf;
    logic [ADDR_W-1:0] if_slot_pc;
    logic [LW-1:0]     ls_slot;
    logic              ls_slot_rw;
    logic              if_ok, ls_ok, gnt_ls, gnt_if, rd_in_flight, suppress;

    assign ls_slot_rw = ls_slot[LW-1];

    // Flushed entries are not eligible at the flush edge.
    always_comb begin
        if_ok        = if_valid && !stop_signal;
        ls_ok        = ls_valid && !(stop_signal && ls_slot_rw == READ_FLAG);
        gnt_ls       = (state_q == ArbIdle) && ls_ok && (!if_ok || burst_cnt_q < BurstMax);
        gnt_if       = (state_q == ArbIdle) && !gnt_ls && if_ok;
        rd_in_flight = (mc_rw_q == READ_FLAG);
        suppress     = rd_in_flight && (squash_q || stop_signal);
    end

    mem_req_arbiter_req_slot #(
        .W (ADDR_W)
    ) u_if_slot (
        .clk_i     (clk),
        .rst_i     (rst),
        .en_i      (rdy),
        .req_i     (if_req),
        .drop_i    (stop_signal),
        .clr_i     (stop_signal),
        .take_i    (gnt_if),
        .payload_i (if_pc),
        .valid_o   (if_valid),
        .payload_o (if_slot_pc),
        .ovf_o     (if_ovf)
    );

    // Loads are flushed; stores survive a flush.
    mem_req_arbiter_req_slot #(
        .W (LW)
    ) u_ls_slot (
        .clk_i     (clk),
        .rst_i     (rst),
        .en_i      (rdy),
        .req_i     (ls_req),
        .drop_i    (stop_signal && ls_rw == READ_FLAG),
        .clr_i     (stop_signal && ls_slot_rw == READ_FLAG),
        .take_i    (gnt_ls),
        .payload_i ({ls_rw, ls_len, ls_addr, ls_wdata}),
        .valid_o   (ls_valid),
        .payload_o (ls_slot),
        .ovf_o     (ls_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ArbIdle;
            owner_q     <= OwnIf;
            squash_q    <= 1'b0;
            burst_cnt_q <= '0;
            if_done_q   <= 1'b0;
            if_inst_q   <= '0;
            ls_done_q   <= 1'b0;
            ls_rdata_q  <= '0;
            mc_start_q  <= 1'b0;
            mc_rw_q     <= READ_FLAG;
            mc_len_q    <= '0;
            mc_addr_q   <= '0;
            mc_wdata_q  <= '0;
            busy_q      <= 1'b0;
            proto_err_q <= 1'b0;
        end else if (rdy) begin
            mc_start_q <= 1'b0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            if (if_ovf || ls_ovf) begin
                proto_err_q <= 1'b1;
            end
            case (state_q)
                ArbIdle: begin
                    if (!if_ok) begin
                        burst_cnt_q <= '0;
                    end else if (gnt_ls) begin
                        burst_cnt_q <= (burst_cnt_q == '1) ? burst_cnt_q : burst_cnt_q + 1'b1;
                    end else if (gnt_if) begin
                        burst_cnt_q <= '0;
                    end
                    if (gnt_ls || gnt_if) begin
                        state_q    <= ArbWait;
                        busy_q     <= 1'b1;
                        mc_start_q <= 1'b1;
                    end
                    if (gnt_ls) begin
                        owner_q    <= OwnLs;
                        mc_rw_q    <= ls_slot_rw;
                        mc_len_q   <= ls_slot[LW-2 -: 3];
                        mc_addr_q  <= ls_slot[ADDR_W+DATA_W-1 -: ADDR_W];
                        mc_wdata_q <= ls_slot[DATA_W-1:0];
                    end else if (gnt_if) begin
                        owner_q    <= OwnIf;
                        mc_rw_q    <= READ_FLAG;
                        mc_len_q   <= FETCH_LEN;
                        mc_addr_q  <= if_slot_pc;
                        mc_wdata_q <= '0;
                    end
                end
                ArbWait: begin
                    if (mc_done) begin
                        state_q  <= ArbIdle;
                        busy_q   <= 1'b0;
                        squash_q <= 1'b0;
                        if (!suppress) begin
                            if (owner_q == OwnIf) begin
                                if_done_q <= 1'b1;
                                if_inst_q <= mc_rdata;
                            end else begin
                                ls_done_q  <= 1'b1;
                                ls_rdata_q <= rd_in_flight ? mc_rdata : '0;
                            end
                        end
                    end else if (stop_signal && rd_in_flight) begin
                        squash_q <= 1'b1;
                    end
                end
                default: state_q <= ArbIdle;
            endcase
        end
    end

    assign if_done   = if_done_q;
    assign if_inst   = if_inst_q;
    assign ls_done   = ls_done_q;
    assign ls_rdata  = ls_rdata_q;
    assign mc_start  = mc_start_q;
    assign mc_rw     = mc_rw_q;
    assign mc_len    = mc_len_q;
    assign mc_addr   = mc_addr_q;
    assign mc_wdata  = mc_wdata_q;
    assign busy      = busy_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
module tb_mem_req_arbiter;

    logic        clk = 1'b0;
    logic        rst, rdy, stop_signal;
    logic        if_req, ls_req, ls_rw, mc_done;
    logic [31:0] if_pc, ls_addr, ls_wdata, mc_rdata;
    logic [2:0]  ls_len;
    logic        if_done, ls_done, mc_start, mc_rw, busy, proto_err;
    logic [31:0] if_inst, ls_rdata, mc_addr, mc_wdata;
    logic [2:0]  mc_len;
    logic [136:0] outs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_req_arbiter dut (
        .clk(clk), .rst(rst), .rdy(rdy), .stop_signal(stop_signal),
        .if_req(if_req), .if_pc(if_pc), .if_done(if_done), .if_inst(if_inst),
        .ls_req(ls_req), .ls_rw(ls_rw), .ls_len(ls_len), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .mc_start(mc_start), .mc_rw(mc_rw), .mc_len(mc_len), .mc_addr(mc_addr),
        .mc_wdata(mc_wdata), .mc_done(mc_done), .mc_rdata(mc_rdata),
        .busy(busy), .proto_err(proto_err)
    );

    assign outs = {if_done, if_inst, ls_done, ls_rdata, mc_start, mc_rw, mc_len, mc_addr,
                   mc_wdata, busy, proto_err};

    // ---------------- behavioural reference model ----------------
    logic        m_if_v, m_ls_v, m_ls_rw, m_busy, m_own_ls, m_rw, m_squash, m_err;
    logic [31:0] m_if_pc, m_ls_addr, m_ls_wd, m_addr, m_wd, m_if_inst, m_ls_rdata;
    logic [2:0]  m_ls_len, m_len;
    logic        m_start, m_if_done, m_ls_done;
    int          m_cnt;

    task automatic model_reset();
        {m_if_v, m_ls_v, m_ls_rw, m_busy, m_own_ls, m_rw, m_squash, m_err} = '0;
        {m_if_pc, m_ls_addr, m_ls_wd, m_addr, m_wd, m_if_inst, m_ls_rdata} = '0;
        m_ls_len = '0; m_len = '0;
        {m_start, m_if_done, m_ls_done} = '0;
        m_cnt = 0;
    endtask

    // One clock edge of the arbiter rules, applied to the inputs present at that edge.
    task automatic model_step();
        logic if_ok, ls_ok, g_ls, g_if, rd, clr;
        if (!rdy) return;
        m_start = 0; m_if_done = 0; m_ls_done = 0;
        if_ok = m_if_v && !stop_signal;
        ls_ok = m_ls_v && !(stop_signal && !m_ls_rw);
        g_ls  = !m_busy && ls_ok && (!if_ok || m_cnt < 4);
        g_if  = !m_busy && !g_ls && if_ok;
        rd    = !m_rw;
        if (m_busy) begin
            if (mc_done) begin
                m_busy = 0;
                if (!(rd && (m_squash || stop_signal))) begin
                    if (m_own_ls) begin m_ls_done = 1; m_ls_rdata = m_rw ? 32'h0 : mc_rdata; end
                    else begin m_if_done = 1; m_if_inst = mc_rdata; end
                end
                m_squash = 0;
            end else if (stop_signal && rd) begin
                m_squash = 1;
            end
        end else begin
            if (!if_ok) m_cnt = 0;
            else if (g_ls) m_cnt = (m_cnt >= 7) ? 7 : m_cnt + 1;
            else if (g_if) m_cnt = 0;
            if (g_ls) begin
                m_busy = 1; m_start = 1; m_own_ls = 1; m_rw = m_ls_rw; m_len = m_ls_len;
                m_addr = m_ls_addr; m_wd = m_ls_wd;
            end else if (g_if) begin
                m_busy = 1; m_start = 1; m_own_ls = 0; m_rw = 0; m_len = 3'd4;
                m_addr = m_if_pc; m_wd = 32'h0;
            end
        end
        if (if_req && !stop_signal) begin
            if (!m_if_v || g_if) begin m_if_v = 1; m_if_pc = if_pc; end
            else m_err = 1;
        end else if (g_if || stop_signal) begin
            m_if_v = 0;
        end
        clr = stop_signal && m_ls_v && !m_ls_rw;
        if (ls_req && !(stop_signal && !ls_rw)) begin
            if (!m_ls_v || g_ls || clr) begin
                m_ls_v = 1; m_ls_rw = ls_rw; m_ls_len = ls_len; m_ls_addr = ls_addr;
                m_ls_wd = ls_wdata;
            end else m_err = 1;
        end else if (g_ls || clr) begin
            m_ls_v = 0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        {stop_signal, if_req, ls_req, ls_rw, mc_done} = '0;
        {if_pc, ls_addr, ls_wdata, mc_rdata} = '0;
        ls_len = '0;
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; clear_inputs();
        tick(); tick();
        checks++; if (outs !== '0) begin errors++; $display("FAIL reset_outs got %h want 0", outs); end
        rst = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || mc_start !== 1'b0) begin
            errors++; $display("FAIL reset_idle got busy=%b start=%b want 0 0", busy, mc_start);
        end
    endtask

    task automatic test_single_fetch();
        if_req = 1; if_pc = 32'h100;
        tick(); if_req = 0;
        checks++; if (mc_start !== 1'b0) begin errors++; $display("FAIL fetch_latency got start=%b want 0", mc_start); end
        tick();
        checks++; if ({mc_start, mc_rw, mc_len, mc_addr, busy} !== {1'b1, 1'b0, 3'd4, 32'h100, 1'b1}) begin
            errors++; $display("FAIL fetch_issue got start=%b rw=%b len=%0d addr=%h busy=%b want 1 0 4 100 1",
                               mc_start, mc_rw, mc_len, mc_addr, busy);
        end
        tick();
        checks++; if (mc_start !== 1'b0 || mc_addr !== 32'h100) begin
            errors++; $display("FAIL fetch_hold got start=%b addr=%h want 0 100", mc_start, mc_addr);
        end
        mc_done = 1; mc_rdata = 32'h00A00093;
        tick(); mc_done = 0;
        checks++; if ({if_done, if_inst, busy, ls_done} !== {1'b1, 32'h00A00093, 1'b0, 1'b0}) begin
            errors++; $display("FAIL fetch_done got done=%b inst=%h busy=%b want 1 00a00093 0", if_done, if_inst, busy);
        end
        tick();
        checks++; if (if_done !== 1'b0 || if_inst !== 32'h00A00093) begin
            errors++; $display("FAIL fetch_pulse got done=%b inst=%h want 0 00a00093", if_done, if_inst);
        end
    endtask

    task automatic test_simultaneous();
        if_req = 1; if_pc = 32'h200; ls_req = 1; ls_rw = 0; ls_len = 3'd4; ls_addr = 32'h1000;
        tick(); if_req = 0; ls_req = 0;
        tick();
        checks++; if (mc_start !== 1'b1 || mc_addr !== 32'h1000 || mc_rw !== 1'b0) begin
            errors++; $display("FAIL sim_ls_first got start=%b addr=%h want 1 1000", mc_start, mc_addr);
        end
        mc_done = 1; mc_rdata = 32'h11111111;
        tick(); mc_done = 0;
        checks++; if ({ls_done, ls_rdata, if_done, mc_start} !== {1'b1, 32'h11111111, 1'b0, 1'b0}) begin
            errors++; $display("FAIL sim_ls_done got done=%b data=%h ifd=%b start=%b want 1 11111111 0 0",
                               ls_done, ls_rdata, if_done, mc_start);
        end
        tick();
        checks++; if (mc_start !== 1'b1 || mc_addr !== 32'h200 || mc_len !== 3'd4) begin
            errors++; $display("FAIL sim_if_next got start=%b addr=%h len=%0d want 1 200 4", mc_start, mc_addr, mc_len);
        end
        mc_done = 1; mc_rdata = 32'h22222222;
        tick(); mc_done = 0;
        checks++; if ({if_done, if_inst, ls_done} !== {1'b1, 32'h22222222, 1'b0}) begin
            errors++; $display("FAIL sim_if_done got done=%b inst=%h want 1 22222222", if_done, if_inst);
        end
    endtask

    task automatic test_starvation();
        logic [31:0] exp_addr [6];
        bit          refill [6];
        exp_addr = '{32'h4000, 32'h4001, 32'h4002, 32'h4003, 32'h300, 32'h4004};
        refill   = '{1, 1, 1, 1, 0, 0};
        if_req = 1; if_pc = 32'h300; ls_req = 1; ls_rw = 0; ls_len = 3'd2; ls_addr = 32'h4000;
        tick(); if_req = 0;
        for (int i = 0; i < 6; i++) begin
            // Refill the LSU slot on the edge it is granted.
            ls_req = refill[i]; ls_addr = 32'h4001 + 32'(i);
            tick(); ls_req = 0;
            checks++; if (mc_start !== 1'b1 || mc_addr !== exp_addr[i]) begin
                errors++; $display("FAIL starve_grant%0d got start=%b addr=%h want 1 %h", i, mc_start, mc_addr, exp_addr[i]);
            end
            mc_done = 1; mc_rdata = 32'h3000 + 32'(i);
            tick(); mc_done = 0;
        end
        checks++; if (proto_err !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL starve_clean got err=%b busy=%b want 0 0", proto_err, busy);
        end
    endtask

    task automatic test_flush_in_flight();
        ls_req = 1; ls_rw = 0; ls_len = 3'd4; ls_addr = 32'h2000;
        tick(); ls_req = 0;
        tick();
        if_req = 1; if_pc = 32'h400; ls_req = 1; ls_rw = 1; ls_len = 3'd1; ls_addr = 32'h30000;
        ls_wdata = 32'h000000AB;
        tick(); if_req = 0; ls_req = 0;
        stop_signal = 1;
        tick(); stop_signal = 0;
        mc_done = 1; mc_rdata = 32'hDEADBEEF;
        tick(); mc_done = 0;
        checks++; if (ls_done !== 1'b0 || busy !== 1'b0 || if_done !== 1'b0) begin
            errors++; $display("FAIL flush_squash got ls_done=%b busy=%b if_done=%b want 0 0 0", ls_done, busy, if_done);
        end
        tick();
        checks++; if ({mc_start, mc_rw, mc_len, mc_addr, mc_wdata} !== {1'b1, 1'b1, 3'd1, 32'h30000, 32'hAB}) begin
            errors++; $display("FAIL flush_store got start=%b rw=%b len=%0d addr=%h wd=%h want 1 1 1 30000 ab",
                               mc_start, mc_rw, mc_len, mc_addr, mc_wdata);
        end
        mc_done = 1; mc_rdata = 32'h55555555;
        tick(); mc_done = 0;
        checks++; if (ls_done !== 1'b1 || ls_rdata !== 32'h0) begin
            errors++; $display("FAIL flush_store_done got done=%b data=%h want 1 0", ls_done, ls_rdata);
        end
        tick(); tick(); tick();
        checks++; if (mc_start !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL flush_if_dropped got start=%b busy=%b want 0 0", mc_start, busy);
        end
    endtask

    task automatic test_store_immunity();
        ls_req = 1; ls_rw = 1; ls_len = 3'd2; ls_addr = 32'h5000; ls_wdata = 32'h1234;
        tick(); ls_req = 0;
        tick();
        stop_signal = 1;
        tick(); tick();
        mc_done = 1; mc_rdata = 32'h99999999;
        tick(); mc_done = 0; stop_signal = 0;
        checks++; if ({ls_done, ls_rdata, busy} !== {1'b1, 32'h0, 1'b0}) begin
            errors++; $display("FAIL store_immune got done=%b data=%h busy=%b want 1 0 0", ls_done, ls_rdata, busy);
        end
    endtask

    task automatic test_overflow_reset();
        ls_req = 1; ls_rw = 0; ls_len = 3'd4; ls_addr = 32'h7000;
        tick(); ls_req = 0;
        tick();
        if_req = 1; if_pc = 32'h600;
        tick(); if_pc = 32'h700;
        tick(); if_req = 0;
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", proto_err); end
        mc_done = 1; mc_rdata = 32'h77;
        tick(); mc_done = 0;
        tick();
        checks++; if (mc_start !== 1'b1 || mc_addr !== 32'h600 || proto_err !== 1'b1) begin
            errors++; $display("FAIL ovf_retain got start=%b addr=%h err=%b want 1 600 1", mc_start, mc_addr, proto_err);
        end
        #2 rst = 1;
        #1;
        checks++; if (outs !== '0) begin errors++; $display("FAIL async_reset got %h want 0", outs); end
        tick(); rst = 0;
        model_reset();
    endtask

    task automatic test_random();
        logic [136:0] exp;
        int           shown = 0;
        logic [2:0]   lens [3];
        lens = '{3'd1, 3'd2, 3'd4};
        for (int c = 0; c < 3000; c++) begin
            if (c % 750 == 749) begin
                rst = 1; tick(); rst = 0; model_reset();
            end
            rdy         = ($urandom_range(0, 9) != 0);
            if_req      = rdy && (m_if_v ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) == 0));
            if_pc       = $urandom;
            ls_req      = rdy && (m_ls_v ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) == 0));
            ls_rw       = 1'($urandom_range(0, 1));
            ls_len      = lens[$urandom_range(0, 2)];
            ls_addr     = $urandom;
            ls_wdata    = $urandom;
            stop_signal = ($urandom_range(0, 11) == 0);
            mc_done     = m_busy && ($urandom_range(0, 2) == 0);
            mc_rdata    = $urandom;
            @(posedge clk);
            model_step();
            @(negedge clk);
            exp = {m_if_done, m_if_inst, m_ls_done, m_ls_rdata, m_start, m_rw, m_len, m_addr, m_wd,
                   m_busy, m_err};
            checks++;
            if (outs !== exp) begin
                errors++;
                if (shown < 20) begin
                    shown++;
                    $display("FAIL random_cycle%0d got %h want %h", c, outs, exp);
                end
            end
        end
        clear_inputs(); rdy = 1;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_starvation();
        test_flush_in_flight();
        test_store_immunity();
        test_overflow_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
Front-end arbiter and sequencer for the byte-serial memory controller. It captures one-cycle request pulses from instruction fetch (IF) and the load/store unit (LSU) into 1-deep slots. It grants exactly one transaction at a time to the controller and routes each completion back to its owner. It enforces LSU priority with a bounded-starvation guarantee for IF, and applies pipeline flush (stop) semantics to pending and in-flight reads.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data / instruction width
LS_BURST_MAX, 4, max consecutive LSU grants while IF is pending; must be at least 1
CNT_W, 3, width of the burst counter; must satisfy 2^CNT_W > LS_BURST_MAX

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
rdy  in  1  global enable; when 0 all state and outputs hold
stop_signal  in  1  pipeline flush, level
if_req  in  1  IF request pulse
if_pc  in  ADDR_W  fetch address, valid with if_req
if_done  out  1  one-cycle fetch completion pulse
if_inst  out  DATA_W  fetched instruction, valid with if_done
ls_req  in  1  LSU request pulse
ls_rw  in  1  0 = read, 1 = write
ls_len  in  3  byte count: 1, 2 or 4
ls_addr  in  ADDR_W  access address
ls_wdata  in  DATA_W  store data
ls_done  out  1  one-cycle LSU completion pulse
ls_rdata  out  DATA_W  load data, valid with ls_done
mc_start  out  1  one-cycle start pulse to the memory controller
mc_rw  out  1  0 = read, 1 = write
mc_len  out  3  byte count
mc_addr  out  ADDR_W  access address
mc_wdata  out  DATA_W  store data
mc_done  in  1  controller completion pulse
mc_rdata  in  DATA_W  controller read data, valid with mc_done
busy  out  1  high while a transaction is in flight
proto_err  out  1  sticky flag: request pulse arrived while its slot was already full

Behaviour:
- Reset, asynchronous: every output is 0, both slots are empty, the state is IDLE, the burst counter is 0 and the squash flag is 0.
- rdy=0: nothing updates. Upstream must not pulse requests while rdy=0.
- if_done, ls_done and mc_start are registered pulses, high for exactly one cycle.
- Slot capture:
  - A request pulse at edge E sets its slot valid after E and latches its payload.
  - A slot that is being granted at E may capture a new pulse at the same edge E.
  - A pulse into a full slot that is not being granted at E: the new payload is dropped and proto_err is set. proto_err clears only on reset.
- States:
  - IDLE -> WAIT when a grant occurs at edge E. mc_start and the mc_* payload are registered at E, busy=1 and the granted slot is cleared. A slot filled at edge E is eligible from edge E+1 onward, so the minimum pulse-to-start latency is 1 cycle.
  - WAIT -> IDLE at the edge where mc_done=1. The completion is routed to its owner at that edge. No new grant is issued at that same edge; the next grant comes at the following edge at the earliest.
- Grant rule in IDLE:
  - LSU slot valid and (IF slot empty or burst_cnt < LS_BURST_MAX): grant LSU, burst_cnt++ (saturating).
  - Otherwise, if the IF slot is valid: grant IF, burst_cnt = 0.
  - burst_cnt also resets to 0 on any IDLE cycle with the IF slot empty.
- A fetch is issued with mc_rw=0 and mc_len=4.
- mc_addr, mc_len, mc_rw and mc_wdata hold their values after the mc_start pulse until the next grant.
- stop_signal=1 at edge E:
  - The IF slot is cleared, and an if_req arriving at E is dropped.
  - The LSU slot is cleared only if it holds a read. Stores are never dropped; an ls_req store arriving at E is captured.
  - If a fetch or load is in flight, squash=1. The arbiter still waits for mc_done, but the matching if_done/ls_done is suppressed. squash clears when that mc_done arrives.
  - An in-flight store is unaffected and acknowledges normally.
  - stop_signal coinciding with mc_done of a fetch or load suppresses that done.
- Completion data: if_inst and ls_rdata take the value of mc_rdata at the done edge and hold it until the next done for that owner. ls_rdata is 0 for store completions.

Decomposition:
- Shared constant include (existing constant.v): READ_FLAG / WRITE_FLAG, ADDR_TYPE / DATA_TYPE widths, and the arbiter state encoding (ARB_IDLE, ARB_WAIT), plus an owner encoding (OWN_IF, OWN_LS).
- One natural sub-module, req_slot: a 1-deep pulse-capture buffer with valid, payload, a clear input, a grant-and-refill input and an overflow output. It is instantiated twice, with payload width as a parameter.

Test Plan:
1. Single fetch: if_req with pc=0x100 at cycle 0 -> mc_start=1, mc_addr=0x100, mc_len=4 at cycle 2. Then mc_done with rdata=0x00A00093 -> if_done=1, if_inst=0x00A00093 the next cycle; busy falls.
2. Simultaneous pulses: if_req (0x200) and ls_req read (0x1000, len 4) at the same cycle -> the LSU is granted first. IF is granted one cycle after the LSU mc_done. Both dones are delivered in that order.
3. Starvation bound with LS_BURST_MAX=4: keep the LSU slot continuously refilled while the IF slot is pending -> exactly 4 LSU grants, then 1 IF grant, then the LSU resumes.
4. Flush in flight: a load is granted, then stop_signal is raised before mc_done -> no ls_done is produced, and busy drops on mc_done. A queued IF request is dropped, and a queued store (0x30000, len 1) is still issued afterwards.
5. Store immunity: a store is in flight with stop_signal=1 for 3 cycles -> ls_done still fires on mc_done.
6. Overflow and reset: a second if_req arrives while the IF slot is full and not granted -> proto_err=1, and the first payload is retained. Asserting rst mid-WAIT clears every output immediately, without waiting for a clock edge.
